// File: rtl/packer_cfg_pkg.sv
// Shared types and encodings for loading dataPacker config over its byte-serial bus.
// Latency: n/a (definitions only).
// Backpressure: n/a.
package packer_cfg_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        DRAIN = 2'd1,
        SEND  = 2'd2,
        GAP   = 2'd3
    } seq_state_t;

    // Per-chain firmware byte values understood by the packer
    localparam logic [7:0] FW_N   = 8'd0;
    localparam logic [7:0] FW_M   = 8'd1;
    localparam logic [7:0] FW_ONE = 8'd2;

    // Bit positions inside a per-chain cond byte
    localparam int LAST0     = 0;
    localparam int NOTLAST0  = 1;
    localparam int FIRST0    = 2;
    localparam int NOTFIRST0 = 3;
    localparam int LAST1     = 4;
    localparam int NOTLAST1  = 5;
    localparam int FIRST1    = 6;
    localparam int NOTFIRST1 = 7;

    localparam logic [7:0] DEFAULT_IDLE_ID = 8'hFF;

endpackage

// File: rtl/packer_config_sequencer.sv
// Stops tracing, drains, streams shadow cond/firmware bytes to one packer, resumes tracing.
// Latency: busy for DRAIN_CYCLES + 2*MAX_CHAINS + GAP_CYCLES cycles after start.
// Backpressure: none; one byte per cycle, start and writes while busy are dropped.
module packer_config_sequencer
    import packer_cfg_pkg::*;
#(
    parameter int         MAX_CHAINS   = 4,
    parameter logic [7:0] TARGET_ID    = 8'd0,
    parameter logic [7:0] IDLE_ID      = DEFAULT_IDLE_ID,
    parameter int         DRAIN_CYCLES = 4,
    parameter int         GAP_CYCLES   = 1
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic                          cfg_wr_en,
    input  logic                          cfg_wr_sel,
    input  logic [$clog2(MAX_CHAINS)-1:0] cfg_wr_chain,
    input  logic [7:0]                    cfg_wr_data,
    input  logic                          start,
    input  logic                          trace_enable,
    output logic                          tracing,
    output logic [7:0]                    configId,
    output logic [7:0]                    configData,
    output logic                          busy,
    output logic                          done,
    output logic                          wr_err
);

    localparam int NB   = 2 * MAX_CHAINS;
    localparam int KW   = $clog2(NB);
    localparam int CMAX = (DRAIN_CYCLES > GAP_CYCLES) ? DRAIN_CYCLES : GAP_CYCLES;
    localparam int CW   = (CMAX > 1) ? $clog2(CMAX) : 1;

    seq_state_t    state;
    logic [KW-1:0] k;
    logic [KW-1:0] k_nxt;
    logic [CW-1:0] cnt;
    logic [CW-1:0] cnt_nxt;
    logic [KW-1:0] wr_idx;
    // Bytes 0..MAX_CHAINS-1 are cond, the rest firmware: streaming order equals index order
    logic [7:0]    shadow [NB];

    always_comb begin
        k_nxt   = k + KW'(1);
        cnt_nxt = cnt + CW'(1);
        wr_idx  = cfg_wr_sel ? (KW'(MAX_CHAINS) + KW'(cfg_wr_chain)) : KW'(cfg_wr_chain);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            k          <= '0;
            cnt        <= '0;
            tracing    <= 1'b0;
            configId   <= IDLE_ID;
            configData <= '0;
            busy       <= 1'b0;
            done       <= 1'b0;
            wr_err     <= 1'b0;
            for (int i = 0; i < NB; i++) shadow[i] <= '0;
        end else begin
            done   <= 1'b0;
            wr_err <= 1'b0;
            case (state)
                IDLE: begin
                    tracing    <= trace_enable;
                    configId   <= IDLE_ID;
                    configData <= '0;
                    busy       <= 1'b0;
                    if (cfg_wr_en) shadow[wr_idx] <= cfg_wr_data;
                    if (start) begin
                        state   <= DRAIN;
                        cnt     <= '0;
                        tracing <= 1'b0;
                        busy    <= 1'b1;
                    end
                end
                DRAIN: begin
                    wr_err <= cfg_wr_en;
                    if (cnt == CW'(DRAIN_CYCLES - 1)) begin
                        state      <= SEND;
                        k          <= '0;
                        configId   <= TARGET_ID;
                        configData <= shadow[0];
                    end else begin
                        cnt <= cnt_nxt;
                    end
                end
                SEND: begin
                    wr_err <= cfg_wr_en;
                    if (k == KW'(NB - 1)) begin
                        state      <= GAP;
                        cnt        <= '0;
                        configId   <= IDLE_ID;
                        configData <= '0;
                        done       <= (GAP_CYCLES == 1);
                    end else begin
                        k          <= k_nxt;
                        configData <= shadow[k_nxt];
                    end
                end
                GAP: begin
                    wr_err <= cfg_wr_en;
                    if (cnt == CW'(GAP_CYCLES - 1)) begin
                        state   <= IDLE;
                        busy    <= 1'b0;
                        tracing <= trace_enable;
                    end else begin
                        cnt  <= cnt_nxt;
                        done <= (cnt_nxt == CW'(GAP_CYCLES - 1));
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_packer_config_sequencer.sv
// Self-checking bench: per-cycle timeline reference model, table of load scenarios, hand corner cases.
module tb_packer_config_sequencer;

    localparam int         M     = 4;
    localparam logic [7:0] TGT   = 8'd0;
    localparam logic [7:0] IDLEV = 8'hFF;
    localparam int         DR    = 4;
    localparam int         GP    = 1;
    localparam int         TOTAL = DR + 2 * M + GP;

    logic       clk = 1'b0;
    logic       rst_n = 1'b1;
    logic       cfg_wr_en = 1'b0;
    logic       cfg_wr_sel = 1'b0;
    logic [1:0] cfg_wr_chain = '0;
    logic [7:0] cfg_wr_data = '0;
    logic       start = 1'b0;
    logic       trace_enable = 1'b1;
    logic       tracing, busy, done, wr_err;
    logic [7:0] configId, configData;

    int checks = 0;
    int failures = 0;

    always #5 clk = ~clk;

    packer_config_sequencer #(
        .MAX_CHAINS(M), .TARGET_ID(TGT), .IDLE_ID(IDLEV),
        .DRAIN_CYCLES(DR), .GAP_CYCLES(GP)
    ) dut (
        .clk(clk), .rst_n(rst_n),
        .cfg_wr_en(cfg_wr_en), .cfg_wr_sel(cfg_wr_sel),
        .cfg_wr_chain(cfg_wr_chain), .cfg_wr_data(cfg_wr_data),
        .start(start), .trace_enable(trace_enable),
        .tracing(tracing), .configId(configId), .configData(configData),
        .busy(busy), .done(done), .wr_err(wr_err)
    );

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h required=%h at %0t", nm, act, exp, $time);
        end
    endtask

    // Reference: ref_t is the position (1..TOTAL) inside a load sequence, 0 when idle
    int         ref_t;
    logic [7:0] ref_sh [2*M];
    logic       exp_tr;
    logic       exp_werr;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ref_t = 0;
            for (int i = 0; i < 2 * M; i++) ref_sh[i] = 8'h00;
            exp_tr = 1'b0;
            exp_werr = 1'b0;
        end else if (ref_t == 0) begin
            exp_werr = 1'b0;
            if (cfg_wr_en)
                ref_sh[cfg_wr_sel ? M + int'(cfg_wr_chain) : int'(cfg_wr_chain)] = cfg_wr_data;
            if (start) begin
                ref_t = 1;
                exp_tr = 1'b0;
            end else begin
                exp_tr = trace_enable;
            end
        end else begin
            exp_werr = cfg_wr_en;
            if (ref_t == TOTAL) begin
                ref_t = 0;
                exp_tr = trace_enable;
            end else begin
                ref_t = ref_t + 1;
                exp_tr = 1'b0;
            end
        end
    end

    function automatic logic [19:0] expected_outs();
        bit         sending = (ref_t > DR) && (ref_t <= DR + 2 * M);
        logic [7:0] id      = sending ? TGT : IDLEV;
        logic [7:0] dat     = sending ? ref_sh[ref_t - DR - 1] : 8'h00;
        return {exp_tr, id, dat, ref_t != 0, ref_t == TOTAL, exp_werr};
    endfunction

    always @(negedge clk)
        chk("cycle_outputs", {44'd0, tracing, configId, configData, busy, done, wr_err},
            {44'd0, expected_outs()});

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic set_wr(input logic en, input logic sel, input logic [1:0] ch, input logic [7:0] d);
        cfg_wr_en = en; cfg_wr_sel = sel; cfg_wr_chain = ch; cfg_wr_data = d;
    endtask

    task automatic write_byte(input logic sel, input logic [1:0] ch, input logic [7:0] d);
        set_wr(1'b1, sel, ch, d);
        tick();
        cfg_wr_en = 1'b0;
    endtask

    // Pulses start (with whatever write is already set up), then watches a fixed window
    task automatic do_load(input string nm, input logic [63:0] exp_stream, input bit disturb);
        logic [63:0] got = '0;
        int nb = 0, busy_cnt = 0, done_at = 0, werr_cnt = 0;
        start = 1'b1;
        tick();
        start = 1'b0;
        cfg_wr_en = 1'b0;
        for (int c = 1; c <= TOTAL + 3; c++) begin
            @(negedge clk);
            if (busy) busy_cnt++;
            if (configId == TGT) begin got = {got[55:0], configData}; nb++; end
            if (done) done_at = c;
            if (wr_err) werr_cnt++;
            trace_enable = c[0];
            start = disturb && (c == DR + 3);
            if (disturb && c == 2) set_wr(1'b1, 1'b0, 2'd1, 8'hAA);
            else cfg_wr_en = 1'b0;
        end
        start = 1'b0;
        chk({nm, "_stream"}, got, exp_stream);
        chk({nm, "_nbytes"}, 64'(nb), 64'(2 * M));
        chk({nm, "_busy_width"}, 64'(busy_cnt), 64'(TOTAL));
        chk({nm, "_done_cycle"}, 64'(done_at), 64'(TOTAL));
        if (disturb) chk({nm, "_wr_err_pulses"}, 64'(werr_cnt), 64'd1);
    endtask

    typedef struct {
        logic        sel;
        logic [1:0]  chain;
        logic [7:0]  data;
        bit          same;
        bit          disturb;
        logic [63:0] exp;
    } vec_t;

    vec_t tbl [6];

    initial begin
        tbl[0] = '{1'b0, 2'd0, 8'h01, 1'b0, 1'b0, 64'h01000000_00000000};
        tbl[1] = '{1'b1, 2'd0, 8'h02, 1'b0, 1'b0, 64'h01000000_02000000};
        tbl[2] = '{1'b1, 2'd3, 8'h01, 1'b0, 1'b0, 64'h01000000_02000001};
        tbl[3] = '{1'b1, 2'd3, 8'h01, 1'b0, 1'b1, 64'h01000000_02000001};
        tbl[4] = '{1'b0, 2'd2, 8'h08, 1'b1, 1'b0, 64'h01000800_02000001};
        tbl[5] = '{1'b1, 2'd1, 8'h01, 1'b0, 1'b0, 64'h01000800_02010001};

        // Reset with trace_enable high
        #1 rst_n = 1'b0;
        repeat (2) @(negedge clk);
        chk("reset_tracing", 64'(tracing), 64'd0);
        chk("reset_configId", 64'(configId), 64'(IDLEV));
        tick();
        rst_n = 1'b1;
        tick();
        chk("post_reset_tracing", 64'(tracing), 64'd1);
        chk("post_reset_configId", 64'(configId), 64'(IDLEV));
        chk("post_reset_busy", 64'(busy), 64'd0);

        for (int i = 0; i < 6; i++) begin
            if (tbl[i].same) set_wr(1'b1, tbl[i].sel, tbl[i].chain, tbl[i].data);
            else write_byte(tbl[i].sel, tbl[i].chain, tbl[i].data);
            do_load($sformatf("vec%0d", i), tbl[i].exp, tbl[i].disturb);
            tick();
        end

        // tracing follows trace_enable one cycle late once idle
        trace_enable = 1'b1; tick();
        chk("idle_trace_on", 64'(tracing), 64'd1);
        trace_enable = 1'b0; tick();
        chk("idle_trace_off", 64'(tracing), 64'd0);

        // Reset during the third SEND cycle
        start = 1'b1; tick(); start = 1'b0;
        repeat (DR + 2) tick();
        chk("mid_send_configId", 64'(configId), 64'(TGT));
        chk("mid_send_byte", 64'(configData), 64'h08);
        rst_n = 1'b0;
        #1;
        chk("async_reset_outs", {44'd0, tracing, configId, configData, busy, done, wr_err},
            {44'd0, 1'b0, IDLEV, 8'h00, 3'b000});
        tick();
        rst_n = 1'b1;
        tick();
        write_byte(1'b0, 2'd0, 8'h01);
        write_byte(1'b1, 2'd0, 8'h02);
        write_byte(1'b1, 2'd3, 8'h01);
        do_load("after_reset", 64'h01000000_02000001, 1'b0);
        tick();

        // Randomized traffic with occasional resets
        for (int n = 0; n < 3000; n++) begin
            rst_n = ($urandom_range(0, 399) != 0);
            set_wr($urandom_range(0, 3) == 0, 1'($urandom), 2'($urandom), 8'($urandom));
            start = ($urandom_range(0, 11) == 0);
            trace_enable = 1'($urandom);
            tick();
        end
        rst_n = 1'b1;
        set_wr(1'b0, 1'b0, 2'd0, 8'h00);
        start = 1'b0;
        repeat (TOTAL + 2) tick();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
